// File: rtl/dual_pwm_gen.sv
// dual_pwm_gen: two-channel PWM generator with period-boundary double-buffered duty words.
// Optional build macro SLEW_LIMIT_EN limits the per-period change of each applied duty.
`default_nettype none

module dual_pwm_gen #(
   parameter int DUTY_W    = 6,
   parameter int CLK_DIV   = 1000,
   parameter int SLEW_STEP = 4
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DUTY_W-1:0] DC_X,
   input  logic [DUTY_W-1:0] DC_Y,
   output logic              pwm_x,
   output logic              pwm_y,
   output logic              period_start,
   output logic [DUTY_W-1:0] active_x,
   output logic [DUTY_W-1:0] active_y
);

   localparam int                PRE_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_DIV - 1);
   localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'((1 << DUTY_W) - 2);
   localparam logic [DUTY_W:0]   DUTY_MAX   = (DUTY_W+1)'((1 << DUTY_W) - 1);
   localparam logic [DUTY_W:0]   STEP       = (DUTY_W+1)'(SLEW_STEP);

`ifdef SLEW_LIMIT_EN
   localparam bit SLEW_EN = 1'b1;
`else
   localparam bit SLEW_EN = 1'b0;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [DUTY_W-1:0] phase_q, phase_d;
   logic [DUTY_W-1:0] act_x_q, act_x_d;
   logic [DUTY_W-1:0] act_y_q, act_y_d;
   logic              pwm_x_q, pwm_x_d;
   logic              pwm_y_q, pwm_y_d;
   logic              ps_q, ps_d;
   logic              step_tick;

   // Move cur toward req by at most STEP; sums are one bit wider and clamped.
   function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                              input logic [DUTY_W-1:0] req);
      logic [DUTY_W:0] diff;
      logic [DUTY_W:0] sum;
      if (req >= cur) begin
         diff = {1'b0, req} - {1'b0, cur};
         sum  = {1'b0, cur} + STEP;
         if (diff <= STEP)
            return req;
         else if (sum > DUTY_MAX)
            return DUTY_MAX[DUTY_W-1:0];
         else
            return sum[DUTY_W-1:0];
      end else begin
         diff = {1'b0, cur} - {1'b0, req};
         if (diff <= STEP)
            return req;
         else
            return cur - STEP[DUTY_W-1:0];
      end
   endfunction

   function automatic logic [DUTY_W-1:0] reload(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] req);
      return SLEW_EN ? slew(cur, req) : req;
   endfunction

   assign step_tick = (pre_q == PRE_LAST);

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         phase_q <= '0;
         act_x_q <= '0;
         act_y_q <= '0;
         pwm_x_q <= 1'b0;
         pwm_y_q <= 1'b0;
         ps_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         phase_q <= phase_d;
         act_x_q <= act_x_d;
         act_y_q <= act_y_d;
         pwm_x_q <= pwm_x_d;
         pwm_y_q <= pwm_y_d;
         ps_q    <= ps_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      phase_d = phase_q;
      act_x_d = act_x_q;
      act_y_d = act_y_q;
      pwm_x_d = 1'b0;
      pwm_y_d = 1'b0;
      ps_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pre_d   = '0;
            phase_d = '0;
            if (enable) begin
               state_d = ST_RUN;
               act_x_d = reload(act_x_q, DC_X);
               act_y_d = reload(act_y_q, DC_Y);
               ps_d    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               // Dropping enable wins over a coincident period boundary.
               state_d = ST_IDLE;
               pre_d   = '0;
               phase_d = '0;
            end else begin
               pwm_x_d = (phase_q < act_x_q);
               pwm_y_d = (phase_q < act_y_q);
               if (step_tick) begin
                  pre_d = '0;
                  if (phase_q == PHASE_LAST) begin
                     phase_d = '0;
                     act_x_d = reload(act_x_q, DC_X);
                     act_y_d = reload(act_y_q, DC_Y);
                     ps_d    = 1'b1;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pwm_x        = pwm_x_q;
   assign pwm_y        = pwm_y_q;
   assign period_start = ps_q;
   assign active_x     = act_x_q;
   assign active_y     = act_y_q;

endmodule

`default_nettype wire
